// File: rtl/alu_operand_stage.sv
// Operand-preparation and result-capture stage around the low-power ALU's ripple-carry adder.
// Adder inputs are registered and only move on an accepted request, so the adder stays quiet otherwise.
module alu_operand_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] adder_in0,
    output logic [WIDTH-1:0] adder_in1,
    output logic             adder_carry_in,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_INC = 2'd2;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_in_ready;
    logic               w_accept;
    logic [WIDTH-1:0]   w_op_in0;
    logic [WIDTH-1:0]   w_op_in1;
    logic               w_op_cin;
    logic               w_overflow;

    logic [WIDTH-1:0]   r_in0;
    logic [WIDTH-1:0]   r_in1;
    logic               r_cin;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_overflow;
    logic               r_zero;
    logic               r_out_valid;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid must be held until that edge, and ready may depend combinationally on the peer's ready.
    always_comb begin
        w_in_ready   = 1'b0;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next_state = S_EXEC;
            end
            S_EXEC: w_next_state = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_in_ready   = 1'b1;
                    w_next_state = in_valid ? S_EXEC : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (!rst_n) w_in_ready = 1'b0;
    end

    assign w_accept = in_valid & w_in_ready;

    // SUB is a + ~b + 1; INC and PASS ignore operand B entirely.
    always_comb begin
        w_op_in0 = in_a;
        w_op_in1 = '0;
        w_op_cin = 1'b0;
        case (in_op)
            OP_ADD:  w_op_in1 = in_b;
            OP_SUB: begin
                w_op_in1 = ~in_b;
                w_op_cin = 1'b1;
            end
            OP_INC:  w_op_cin = 1'b1;
            default: w_op_cin = 1'b0;
        endcase
    end

    assign w_overflow = (r_in0[WIDTH-1] == r_in1[WIDTH-1]) &&
                        (adder_sum[WIDTH-1] != r_in0[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in0 <= '0;
            r_in1 <= '0;
            r_cin <= 1'b0;
        end else if (w_accept) begin
            r_in0 <= w_op_in0;
            r_in1 <= w_op_in1;
            r_cin <= w_op_cin;
        end
    end

    // Result registers load only at the end of EXEC and hold through any downstream stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_result   <= adder_sum;
            r_carry    <= adder_carry_out;
            r_overflow <= w_overflow;
            r_zero     <= (adder_sum == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_out_valid <= 1'b1;
        end else if (r_state == S_DONE && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready       = w_in_ready;
    assign adder_in0      = r_in0;
    assign adder_in1      = r_in1;
    assign adder_carry_in = r_cin;
    assign out_valid      = r_out_valid;
    assign out_result     = r_result;
    assign out_carry      = r_carry;
    assign out_overflow   = r_overflow;
    assign out_zero       = r_zero;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: a behavioural adder closes the loop, and results are checked
// against an arithmetic reference model through an expected-result queue.
module tb_alu_operand_stage;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] adder_in0;
  logic [W-1:0] adder_in1;
  logic         adder_carry_in;
  logic [W-1:0] adder_sum;
  logic         adder_carry_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_overflow;
  logic         out_zero;
  logic [1:0]   dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  // expected {overflow, carry, zero, result}
  logic [W+2:0] exp_q[$];
  logic [W:0]   exp_in0_in1_hi;
  logic [W-1:0] exp_in0;
  logic [W-1:0] exp_in1;
  logic         exp_cin;

  alu_operand_stage #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_op           (in_op),
    .in_a            (in_a),
    .in_b            (in_b),
    .adder_in0       (adder_in0),
    .adder_in1       (adder_in1),
    .adder_carry_in  (adder_carry_in),
    .adder_sum       (adder_sum),
    .adder_carry_out (adder_carry_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_carry       (out_carry),
    .out_overflow    (out_overflow),
    .out_zero        (out_zero),
    .o_dbg_state     (dbg_state)
  );

  // behavioural ripple-carry adder
  assign {adder_carry_out, adder_sum} = {1'b0, adder_in0} + {1'b0, adder_in1} + {{W{1'b0}}, adder_carry_in};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W+2:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, us, sa, sb, ss;
    logic [W-1:0] r;
    logic c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0:    begin us = ua + ub; ss = sa + sb; end
      2'd1:    begin us = ua - ub; ss = sa - sb; end
      2'd2:    begin us = ua + 1;  ss = sa + 1;  end
      default: begin us = ua;      ss = sa;      end
    endcase
    r = us[W-1:0];
    c = (op == 2'd1) ? (ua >= ub) : (us > 64'sh0FFFF_FFFF);
    v = (ss > SMAX) || (ss < SMIN);
    return {v, c, (r == '0), r};
  endfunction

  task automatic set_exp_ops(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_in0 = a;
    case (op)
      2'd0:    begin exp_in1 = b;  exp_cin = 1'b0; end
      2'd1:    begin exp_in1 = ~b; exp_cin = 1'b1; end
      2'd2:    begin exp_in1 = '0; exp_cin = 1'b1; end
      default: begin exp_in1 = '0; exp_cin = 1'b0; end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ops(input string tag);
    check({tag, "_in0"}, 64'(adder_in0), 64'(exp_in0));
    check({tag, "_in1"}, 64'(adder_in1), 64'(exp_in1));
    check({tag, "_cin"}, 64'(adder_carry_in), 64'(exp_cin));
  endtask

  task automatic check_out(input string tag, input logic [W+2:0] e);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(out_result), 64'(e[W-1:0]));
    check({tag, "_zero"}, 64'(out_zero), 64'(e[W]));
    check({tag, "_carry"}, 64'(out_carry), 64'(e[W+1]));
    check({tag, "_ovf"}, 64'(out_overflow), 64'(e[W+2]));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accept edge (stage in EXEC).
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("issue_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 2'($urandom_range(0, 3));
    in_a     = $urandom;
    in_b     = $urandom;
    exp_q.push_back(ref_result(op, a, b));
    set_exp_ops(op, a, b);
    @(negedge clk);
    check("exec_valid", 64'(out_valid), 64'd0);
    check_ops("accept_ops");
  endtask

  // Called at the EXEC negedge; holds off out_ready for 'stall' cycles, then drains the result.
  task automatic finish_op(input string tag, input int stall);
    logic [W+2:0] e;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check_out(tag, e);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_out({tag, "_stall"}, e);
      check({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
      check_ops({tag, "_stall_ops"});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    issue(op, a, b);
    finish_op(tag, stall);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] corners[6];
  logic [W-1:0] ra, rb, a2, b2;
  logic [1:0]   rop;
  logic [W+2:0] e_bp;

  initial begin
    corners = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_000F};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // reset state
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_flags", 64'({out_carry, out_overflow, out_zero}), 64'd0);
    check("rst_ops", 64'({adder_in0, adder_in1, adder_carry_in}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // directed arithmetic corners
    run_op("add_wrap", 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    issue(2'd1, 32'd5, 32'd7);
    check("sub_in1", 64'(adder_in1), 64'hFFFF_FFF8);
    finish_op("sub_neg", 1);
    run_op("sub_ovf", 2'd1, 32'h8000_0000, 32'h0000_0001, 0);
    run_op("add_ovf", 2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op("inc_wrap", 2'd2, 32'hFFFF_FFFF, 32'h1234_0000, 0);
    run_op("pass", 2'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);

    // backpressure with a new request waiting
    issue(2'd2, 32'h0000_000F, 32'hAAAA_AAAA);
    a2 = 32'h1111_0000;
    b2 = 32'h0000_2222;
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_a     = a2;
    in_b     = b2;
    @(posedge clk);
    e_bp = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out("bp_hold", e_bp);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check_ops("bp_ops");
    end
    check("bp_result_0x10", 64'(out_result), 64'h10);
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.push_back(ref_result(2'd0, a2, b2));
    set_exp_ops(2'd0, a2, b2);
    @(negedge clk);
    check("bp_next_exec_valid", 64'(out_valid), 64'd0);
    check_ops("bp_next_ops");
    finish_op("bp_next", 0);

    // idle isolation
    run_op("iso_pass", 2'd3, 32'h1234_5678, 32'h0BAD_F00D, 0);
    for (int i = 0; i < 10; i++) begin
      in_a  = $urandom;
      in_b  = $urandom;
      in_op = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("iso_in0", 64'(adder_in0), 64'h1234_5678);
      check("iso_in1", 64'(adder_in1), 64'd0);
      check("iso_cin", 64'(adder_carry_in), 64'd0);
      check("iso_valid", 64'(out_valid), 64'd0);
    end

    // asynchronous reset in the middle of EXEC
    issue(2'd0, 32'h0000_0003, 32'h0000_0004);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("amid_ready", 64'(in_ready), 64'd0);
    check("amid_valid", 64'(out_valid), 64'd0);
    check("amid_ops", 64'({adder_in0, adder_in1, adder_carry_in}), 64'd0);
    check("amid_out", 64'({out_result, out_carry, out_overflow, out_zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 64'(out_valid), 64'd0);
    end
    run_op("post_rst", 2'd1, 32'h0000_0010, 32'h0000_0010, 0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
